fixed_align_shifter: RTL and testbench

Sequential alignment stage of the float-to-fixed converter. It takes the unpacked mantissa and sign together with the shift amount and direction produced by the fixed shift calculation stage. It shifts the mantissa one shift-amount bit per cycle (logarithmic stages), applies two's-complement negation and saturation, and hands the fixed-point word downstream over a valid/acknowledge handshake.

---
 rtl/fixed_align_shifter_if.sv | 25 ++
 rtl/fixed_align_shifter.sv | 90 +++++++++
 tb/tb_fixed_align_shifter.sv | 129 ++++++++++++
 3 files changed

// File: rtl/fixed_align_shifter_if.sv
// fixed_align_shifter_if: operand/result handshake bundle for the alignment stage
interface fixed_align_shifter_if #(
  parameter int FIXEDSIZE      = 32,
  parameter int RADIXPOINTSIZE = 6,
  parameter int MANTISSABITS   = 23
);
  logic                      InValid;
  logic                      OutReady;
  logic [MANTISSABITS:0]     InMantissa;
  logic                      InSign;
  logic [RADIXPOINTSIZE-1:0] InShiftAmount;
  logic                      InShiftDirection;
  logic                      OutValid;
  logic                      InAck;
  logic [FIXEDSIZE-1:0]      OutFixed;
  logic                      OutOverflow;
  modport slave (
    input  InValid, InMantissa, InSign, InShiftAmount, InShiftDirection, InAck,
    output OutReady, OutValid, OutFixed, OutOverflow
  );
  modport master (
    output InValid, InMantissa, InSign, InShiftAmount, InShiftDirection, InAck,
    input  OutReady, OutValid, OutFixed, OutOverflow
  );
endinterface

// File: rtl/fixed_align_shifter.sv
// fixed_align_shifter: one log-shift stage per cycle, then negate/saturate into a signed fixed word
module fixed_align_shifter #(
  parameter int FIXEDSIZE      = 32,
  parameter int RADIXPOINTSIZE = 6,
  parameter int MANTISSABITS   = 23
) (
  input logic                   Clk,
  input logic                   RstN,
  fixed_align_shifter_if.slave  io
);
  localparam int MW = MANTISSABITS + 1;
  localparam int EW = FIXEDSIZE > MW ? FIXEDSIZE : MW;
  localparam int IW = $clog2(RADIXPOINTSIZE + 1);
  localparam logic [FIXEDSIZE-1:0] MIN_NEG = {1'b1, {(FIXEDSIZE-1){1'b0}}};
  localparam logic [FIXEDSIZE-1:0] MAX_POS = {1'b0, {(FIXEDSIZE-1){1'b1}}};
  typedef enum logic [1:0] {IDLE, SHIFT, FIXUP, DONE} state_t;
  state_t                    state_q, state_d;
  logic [FIXEDSIZE-1:0]      work_q, work_d;
  logic [RADIXPOINTSIZE-1:0] amt_q, amt_d;
  logic                      dir_q, dir_d, sign_q, sign_d, ovf_q, ovf_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic [EW-1:0]             mant_ext;
  logic [2*FIXEDSIZE-1:0]    wide;
  logic                      big, fix_ovf;
  int unsigned               sh;
  always_comb begin
    mant_ext = EW'(io.InMantissa);
    sh       = 32'd1 << idx_q;
    big      = sh >= 32'(FIXEDSIZE);
    wide     = {{FIXEDSIZE{1'b0}}, work_q} << sh;
    // the exact most-negative magnitude is the one MSB-set value that still fits
    fix_ovf  = ovf_q | (work_q[FIXEDSIZE-1] & ~(sign_q & (work_q == MIN_NEG)));
    state_d  = state_q;
    work_d   = work_q;
    amt_d    = amt_q;
    dir_d    = dir_q;
    sign_d   = sign_q;
    ovf_d    = ovf_q;
    idx_d    = idx_q;
    unique case (state_q)
      IDLE: if (io.InValid) begin
        work_d  = mant_ext[FIXEDSIZE-1:0];
        ovf_d   = (mant_ext >> FIXEDSIZE) != '0;
        amt_d   = io.InShiftAmount;
        dir_d   = io.InShiftDirection;
        sign_d  = io.InSign;
        idx_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (amt_q[idx_q]) begin
          work_d = big ? '0 : dir_q ? work_q >> sh : wide[FIXEDSIZE-1:0];
          ovf_d  = ovf_q | (~dir_q & (big ? work_q != '0 : |wide[2*FIXEDSIZE-1:FIXEDSIZE]));
        end
        idx_d   = idx_q + 1'b1;
        state_d = idx_q == IW'(RADIXPOINTSIZE - 1) ? FIXUP : SHIFT;
      end
      FIXUP: begin
        ovf_d   = fix_ovf;
        work_d  = fix_ovf ? (sign_q ? MIN_NEG : MAX_POS) : sign_q ? -work_q : work_q;
        state_d = DONE;
      end
      DONE: state_d = io.InAck ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      state_q <= IDLE;
      work_q  <= '0;
      amt_q   <= '0;
      dir_q   <= 1'b0;
      sign_q  <= 1'b0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      amt_q   <= amt_d;
      dir_q   <= dir_d;
      sign_q  <= sign_d;
      ovf_q   <= ovf_d;
      idx_q   <= idx_d;
    end
  end
  assign io.OutReady    = state_q == IDLE;
  assign io.OutValid    = state_q == DONE;
  assign io.OutFixed    = state_q == DONE ? work_q : '0;
  assign io.OutOverflow = state_q == DONE & ovf_q;
endmodule

// File: tb/tb_fixed_align_shifter.sv
// tb_fixed_align_shifter: directed vectors with hand-computed results for the alignment stage
module tb_fixed_align_shifter;
  logic Clk = 1'b0;
  logic RstN = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   lat;
  logic [31:0] held;
  fixed_align_shifter_if #(.FIXEDSIZE(32), .RADIXPOINTSIZE(6), .MANTISSABITS(23)) io ();
  fixed_align_shifter #(.FIXEDSIZE(32), .RADIXPOINTSIZE(6), .MANTISSABITS(23)) dut (
    .Clk (Clk),
    .RstN(RstN),
    .io  (io.slave)
  );
  always #5 Clk = ~Clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic accept(input logic [23:0] mant, input logic sign, input logic [5:0] amt, input logic dir);
    @(negedge Clk);
    check("ready_before_accept", 32'(io.OutReady), 32'd1);
    io.InMantissa = mant;
    io.InSign = sign;
    io.InShiftAmount = amt;
    io.InShiftDirection = dir;
    io.InValid = 1'b1;
    @(posedge Clk);
    #1;
    io.InValid = 1'b0;
    io.InMantissa = 24'h5A5A5A;
    io.InSign = ~sign;
    io.InShiftAmount = ~amt;
    io.InShiftDirection = ~dir;
  endtask
  // lat counts rising edges from the accept edge through the edge that raises OutValid, inclusive
  task automatic wait_done(input string tag);
    lat = 1;
    while (io.OutValid !== 1'b1 && lat < 30) begin
      @(posedge Clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd8);
  endtask
  task automatic ack();
    @(negedge Clk);
    io.InAck = 1'b1;
    @(posedge Clk);
    #1;
    io.InAck = 1'b0;
    check("ready_after_ack", 32'(io.OutReady), 32'd1);
    check("valid_after_ack", 32'(io.OutValid), 32'd0);
  endtask
  task automatic op(input string tag, input logic [23:0] mant, input logic sign, input logic [5:0] amt,
                    input logic dir, input logic [31:0] exp_fixed, input logic exp_ovf);
    accept(mant, sign, amt, dir);
    wait_done(tag);
    @(negedge Clk);
    check({tag, "_fixed"}, io.OutFixed, exp_fixed);
    check({tag, "_ovf"}, 32'(io.OutOverflow), 32'(exp_ovf));
    ack();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    io.InValid = 1'b0;
    io.InAck = 1'b0;
    io.InMantissa = '0;
    io.InSign = 1'b0;
    io.InShiftAmount = '0;
    io.InShiftDirection = 1'b0;
    #12;
    check("rst_ready", 32'(io.OutReady), 32'd1);
    check("rst_valid", 32'(io.OutValid), 32'd0);
    check("rst_fixed", io.OutFixed, 32'd0);
    check("rst_ovf", 32'(io.OutOverflow), 32'd0);
    @(negedge Clk);
    RstN = 1'b1;
    op("right_1p5", 24'hC00000, 1'b0, 6'd7, 1'b1, 32'h00018000, 1'b0);
    op("neg_1p5", 24'hC00000, 1'b1, 6'd7, 1'b1, 32'hFFFE8000, 1'b0);
    op("left_amt9", 24'h800000, 1'b0, 6'd9, 1'b0, 32'h7FFFFFFF, 1'b1);
    op("left_amt8_pos", 24'h800000, 1'b0, 6'd8, 1'b0, 32'h7FFFFFFF, 1'b1);
    op("left_amt8_neg", 24'h800000, 1'b1, 6'd8, 1'b0, 32'h80000000, 1'b0);
    op("underflow", 24'hFFFFFF, 1'b1, 6'd24, 1'b1, 32'h00000000, 1'b0);
    op("amt_zero", 24'h800000, 1'b1, 6'd0, 1'b0, 32'hFF800000, 1'b0);
    op("left_fit", 24'hC00000, 1'b0, 6'd4, 1'b0, 32'h0C000000, 1'b0);
    op("left_amt32", 24'h000001, 1'b0, 6'd32, 1'b0, 32'h7FFFFFFF, 1'b1);
    accept(24'hA00000, 1'b0, 6'd20, 1'b1);
    wait_done("bp");
    @(negedge Clk);
    held = io.OutFixed;
    check("bp_fixed", held, 32'h0000000A);
    io.InValid = 1'b1;
    io.InMantissa = 24'hFFFFFF;
    io.InShiftAmount = 6'd1;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      check("bp_valid_hold", 32'(io.OutValid), 32'd1);
      check("bp_fixed_hold", io.OutFixed, 32'h0000000A);
      check("bp_ready_low", 32'(io.OutReady), 32'd0);
    end
    io.InValid = 1'b0;
    ack();
    repeat (3) @(negedge Clk);
    check("bp_no_ghost_valid", 32'(io.OutValid), 32'd0);
    accept(24'hC00000, 1'b0, 6'd7, 1'b1);
    repeat (3) @(posedge Clk);
    #2;
    RstN = 1'b0;
    #1;
    check("midrst_valid", 32'(io.OutValid), 32'd0);
    check("midrst_ready", 32'(io.OutReady), 32'd1);
    check("midrst_fixed", io.OutFixed, 32'd0);
    @(negedge Clk);
    RstN = 1'b1;
    repeat (10) @(negedge Clk);
    check("midrst_no_residual", 32'(io.OutValid), 32'd0);
    op("after_rst", 24'hC00000, 1'b1, 6'd7, 1'b1, 32'hFFFE8000, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
